// File: rtl/hamming_pkg.sv
// Shared Hamming helpers: parity-width sizing and positional data-bit mapping.
// Used by the pipelined decoder and the future encoder.
package hamming_pkg;

    // Smallest r with 2^r >= k + r + 1.
    function automatic int par_w(input int k);
        int r;
        r = 32'sd1;
        while ((32'sd1 << r) < (k + r + 32'sd1)) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int p);
        return (p > 32'sd0) && ((p & (p - 32'sd1)) == 32'sd0);
    endfunction

    // Position (1-based) of data bit idx: the idx-th non-power-of-two position.
    function automatic int data_pos(input int idx);
        int cnt;
        int pos;
        cnt = 32'sd0;
        pos = 32'sd0;
        for (int p = 32'sd1; p <= (32'sd2 * idx + 32'sd3); p++) begin
            if (!is_pow2(p) && (pos == 32'sd0)) begin
                if (cnt == idx) begin
                    pos = p;
                end else begin
                    cnt = cnt + 32'sd1;
                end
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_syn_calc.sv
// Combinational syndrome generator for a positional Hamming codeword.
// With HAMMING_DED_EN defined it also reports the overall parity check.
module hamming_syn_calc
    import hamming_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int PAR_W  = 3,
    parameter int CODE_W = DATA_W + PAR_W
) (
    input  logic [CODE_W-1:0] code,
`ifdef HAMMING_DED_EN
    output logic              par_err,
`endif
    output logic [PAR_W-1:0]  syn
);

    localparam int N = DATA_W + PAR_W;

    // Syndrome is the XOR of the indices of all set positions.
    always_comb begin
        syn = {PAR_W{1'b0}};
        for (int p = 1; p <= N; p++) begin
            if (code[p-1]) begin
                syn = syn ^ PAR_W'(p);
            end else begin
                syn = syn;
            end
        end
    end

`ifdef HAMMING_DED_EN
    assign par_err = ^code;
`endif

endmodule

// File: rtl/hamming_dec_pipe.sv
// Two-stage pipelined Hamming SEC decoder with valid/ready and saturating error counters.
// Define HAMMING_DED_EN for SECDED (extra overall-parity bit at in_code[CODE_W-1]).
module hamming_dec_pipe
    import hamming_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16,
    localparam int PAR_W = par_w(DATA_W),
`ifdef HAMMING_DED_EN
    localparam int CODE_W = DATA_W + PAR_W + 1
`else
    localparam int CODE_W = DATA_W + PAR_W
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PAR_W-1:0]  out_syndrome,
    output logic              out_corr,
    output logic              out_unc,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  unc_cnt
);

    localparam int N = DATA_W + PAR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PAR_W-1:0]  syn_s;
    logic [DATA_W-1:0] raw_data_s, fixed_data_s;
    logic              s1_load_s, s2_load_s, out_hs_s;
    logic              in_range_s, flip_s, corr_s, unc_s;

    logic              s1_v_q, s1_v_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic [PAR_W-1:0]  s1_syn_q, s1_syn_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [PAR_W-1:0]  out_syndrome_q, out_syndrome_d;
    logic              out_corr_q, out_corr_d, out_unc_q, out_unc_d;
    logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d, unc_cnt_q, unc_cnt_d;

`ifdef HAMMING_DED_EN
    logic par_err_s, s1_perr_q, s1_perr_d;

    hamming_syn_calc #(.DATA_W(DATA_W), .PAR_W(PAR_W), .CODE_W(CODE_W)) u_syn (
        .code(in_code), .par_err(par_err_s), .syn(syn_s)
    );
`else
    hamming_syn_calc #(.DATA_W(DATA_W), .PAR_W(PAR_W), .CODE_W(CODE_W)) u_syn (
        .code(in_code), .syn(syn_s)
    );
`endif

    // A stage loads when empty or when its downstream stage loads.
    assign s2_load_s = s1_v_q & (~out_valid_q | out_ready);
    assign in_ready  = ~s1_v_q | ~out_valid_q | out_ready;
    assign s1_load_s = in_valid & in_ready;
    assign out_hs_s  = out_valid_q & out_ready;

    // Gather the data bits out of their non-power-of-two positions.
    always_comb begin
        raw_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < DATA_W; i++) begin
            raw_data_s[i] = in_code[data_pos(i) - 1];
        end
    end

    // S1 next state.
    always_comb begin
        s1_v_d    = s1_v_q;
        s1_data_d = s1_data_q;
        s1_syn_d  = s1_syn_q;
`ifdef HAMMING_DED_EN
        s1_perr_d = s1_perr_q;
`endif
        if (s1_load_s) begin
            s1_v_d    = 1'b1;
            s1_data_d = raw_data_s;
            s1_syn_d  = syn_s;
`ifdef HAMMING_DED_EN
            s1_perr_d = par_err_s;
`endif
        end else if (s2_load_s) begin
            s1_v_d = 1'b0;
        end else begin
            s1_v_d = s1_v_q;
        end
    end

    // Classify the S1 word; a syndrome beyond the last position cannot be corrected.
    always_comb begin
        in_range_s = 1'b0;
        flip_s     = 1'b0;
        corr_s     = 1'b0;
        unc_s      = 1'b0;
        for (int p = 1; p <= N; p++) begin
            if (s1_syn_q == PAR_W'(p)) begin
                in_range_s = 1'b1;
            end else begin
                in_range_s = in_range_s;
            end
        end
`ifdef HAMMING_DED_EN
        if (s1_syn_q == {PAR_W{1'b0}}) begin
            corr_s = s1_perr_q;
        end else if (s1_perr_q && in_range_s) begin
            flip_s = 1'b1;
            corr_s = 1'b1;
        end else begin
            unc_s = 1'b1;
        end
`else
        if (s1_syn_q == {PAR_W{1'b0}}) begin
            corr_s = 1'b0;
        end else if (in_range_s) begin
            flip_s = 1'b1;
            corr_s = 1'b1;
        end else begin
            unc_s = 1'b1;
        end
`endif
    end

    // Flip the data bit whose position the syndrome names.
    always_comb begin
        fixed_data_s = s1_data_q;
        for (int i = 0; i < DATA_W; i++) begin
            fixed_data_s[i] = s1_data_q[i] ^ (flip_s && (s1_syn_q == PAR_W'(data_pos(i))));
        end
    end

    // S2 (output) next state; outputs hold while stalled.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_syndrome_d = out_syndrome_q;
        out_corr_d     = out_corr_q;
        out_unc_d      = out_unc_q;
        if (s2_load_s) begin
            out_valid_d    = 1'b1;
            out_data_d     = fixed_data_s;
            out_syndrome_d = s1_syn_q;
            out_corr_d     = corr_s;
            out_unc_d      = unc_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Counters advance on the output handshake; clear has priority.
    always_comb begin
        corr_cnt_d = corr_cnt_q;
        unc_cnt_d  = unc_cnt_q;
        if (clr_cnt) begin
            corr_cnt_d = {CNT_W{1'b0}};
            unc_cnt_d  = {CNT_W{1'b0}};
        end else begin
            if (out_hs_s && out_corr_q && (corr_cnt_q != CNT_MAX)) begin
                corr_cnt_d = corr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                corr_cnt_d = corr_cnt_q;
            end
            if (out_hs_s && out_unc_q && (unc_cnt_q != CNT_MAX)) begin
                unc_cnt_d = unc_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                unc_cnt_d = unc_cnt_q;
            end
        end
    end

    // Pipeline and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q         <= 1'b0;
            s1_data_q      <= {DATA_W{1'b0}};
            s1_syn_q       <= {PAR_W{1'b0}};
`ifdef HAMMING_DED_EN
            s1_perr_q      <= 1'b0;
`endif
            out_valid_q    <= 1'b0;
            out_data_q     <= {DATA_W{1'b0}};
            out_syndrome_q <= {PAR_W{1'b0}};
            out_corr_q     <= 1'b0;
            out_unc_q      <= 1'b0;
            corr_cnt_q     <= {CNT_W{1'b0}};
            unc_cnt_q      <= {CNT_W{1'b0}};
        end else begin
            s1_v_q         <= s1_v_d;
            s1_data_q      <= s1_data_d;
            s1_syn_q       <= s1_syn_d;
`ifdef HAMMING_DED_EN
            s1_perr_q      <= s1_perr_d;
`endif
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_syndrome_q <= out_syndrome_d;
            out_corr_q     <= out_corr_d;
            out_unc_q      <= out_unc_d;
            corr_cnt_q     <= corr_cnt_d;
            unc_cnt_q      <= unc_cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_syndrome = out_syndrome_q;
    assign out_corr     = out_corr_q;
    assign out_unc      = out_unc_q;
    assign corr_cnt     = corr_cnt_q;
    assign unc_cnt      = unc_cnt_q;

endmodule

// File: tb/tb_hamming_dec_pipe.sv
// Scoreboard bench for hamming_dec_pipe (DATA_W=4, CNT_W=2): directed cases plus random
// words with injected errors, random backpressure, counter saturation/clear and reset.
module tb_hamming_dec_pipe;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 2;
    localparam int PAR_W  = 3;
    localparam int N      = DATA_W + PAR_W;
`ifdef HAMMING_DED_EN
    localparam int CODE_W = N + 1;
    localparam logic [CODE_W-1:0] CW_1011 = 8'h55;
    localparam int MAX_ERR = 2;
`else
    localparam int CODE_W = N;
    localparam logic [CODE_W-1:0] CW_1011 = 7'h55;
    localparam int MAX_ERR = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [PAR_W-1:0]  out_syndrome;
    logic              out_corr, out_unc;
    logic              clr_cnt;
    logic [CNT_W-1:0]  corr_cnt, unc_cnt;

    hamming_dec_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_syndrome(out_syndrome),
        .out_corr(out_corr), .out_unc(out_unc),
        .clr_cnt(clr_cnt), .corr_cnt(corr_cnt), .unc_cnt(unc_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [PAR_W-1:0]  syn;
        logic              corr;
        logic              unc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   bp_rand = 1'b0;
    bit   or_force = 1'b1;
    int   exp_corr_cnt = 0;
    int   exp_unc_cnt = 0;
    bit   prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic [PAR_W-1:0]  prev_syn;
    logic              prev_corr, prev_unc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_p2(input int p);
        return (p > 0) && ((p & (p - 1)) == 0);
    endfunction

    // Reference encoder: data in non-power-of-two positions, even parity per syndrome bit.
    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        int k;
        bit par;
        c = '0;
        k = 0;
        for (int p = 1; p <= N; p++) begin
            if (!is_p2(p)) begin
                c[p-1] = d[k];
                k++;
            end
        end
        for (int p = 1; p <= N; p++) begin
            if (is_p2(p)) begin
                par = 1'b0;
                for (int q = 1; q <= N; q++) begin
                    if (q != p && (q & p) != 0) par = par ^ c[q-1];
                end
                c[p-1] = par;
            end
        end
`ifdef HAMMING_DED_EN
        c[CODE_W-1] = ^c[N-1:0];
`endif
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
        logic [DATA_W-1:0] d;
        int k;
        d = '0;
        k = 0;
        for (int p = 1; p <= N; p++) begin
            if (!is_p2(p)) begin
                d[k] = c[p-1];
                k++;
            end
        end
        return d;
    endfunction

    function automatic exp_t mk(input logic [DATA_W-1:0] d, input logic [PAR_W-1:0] s,
                                input logic c, input logic u);
        exp_t e;
        e.data = d; e.syn = s; e.corr = c; e.unc = u;
        return e;
    endfunction

    // Build a word from random data with nerr distinct flipped positions.
    task automatic gen(input int nerr, output logic [CODE_W-1:0] c, output exp_t e);
        logic [DATA_W-1:0] d;
        int p1, p2, s1, s2;
        d  = DATA_W'($urandom);
        c  = encode(d);
        p1 = $urandom_range(1, CODE_W);
        p2 = $urandom_range(1, CODE_W - 1);
        if (p2 >= p1) p2 = p2 + 1;
        s1 = (p1 <= N) ? p1 : 0;
        s2 = (p2 <= N) ? p2 : 0;
        if (nerr == 0) begin
            e = mk(d, '0, 1'b0, 1'b0);
        end else if (nerr == 1) begin
            c[p1-1] = ~c[p1-1];
            e = mk(d, PAR_W'(s1), 1'b1, 1'b0);
        end else begin
            c[p1-1] = ~c[p1-1];
            c[p2-1] = ~c[p2-1];
            e = mk(extract(c), PAR_W'(s1 ^ s2), 1'b0, 1'b1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [CODE_W-1:0] c, input exp_t e);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_code  = c;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(e);
                done = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) check("drain_timeout", sb_q.size(), 0);
        repeat (2) @(negedge clk);
        tick();
    endtask

    task automatic pulse_reset();
        tick();
        rst_n = 1'b0;
        sb_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Output ready: forced by the sequence, or random while bp_rand is set.
    always @(posedge clk) begin
        #2;
        out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : or_force;
    end

    // Monitor: counters, stall stability and scoreboard pop on each output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            check("rst_out_flags", {out_syndrome, out_corr, out_unc}, 0);
            check("rst_counters", {corr_cnt, unc_cnt}, 0);
            exp_corr_cnt = 0;
            exp_unc_cnt  = 0;
            prev_stall   = 1'b0;
        end else begin
            check("corr_cnt", corr_cnt, exp_corr_cnt);
            check("unc_cnt", unc_cnt, exp_unc_cnt);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_stable", {out_data, out_syndrome, out_corr, out_unc},
                      {prev_data, prev_syn, prev_corr, prev_unc});
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_syndrome", out_syndrome, e.syn);
                    check("out_corr", out_corr, e.corr);
                    check("out_unc", out_unc, e.unc);
                    if (e.corr && exp_corr_cnt < (1 << CNT_W) - 1) exp_corr_cnt++;
                    if (e.unc && exp_unc_cnt < (1 << CNT_W) - 1) exp_unc_cnt++;
                end
            end
            if (clr_cnt) begin
                exp_corr_cnt = 0;
                exp_unc_cnt  = 0;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_syn   = out_syndrome;
            prev_corr  = out_corr;
            prev_unc   = out_unc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CODE_W-1:0] c;
        exp_t e;
        int n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_code  = '0;
        clr_cnt  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);
        check("out_valid_after_reset", out_valid, 0);
        tick();

        // Directed: clean, single error at position 5, DED double error.
        send(CW_1011, mk(4'b1011, 3'd0, 1'b0, 1'b0));
        send(CW_1011 ^ (CODE_W'(1) << 4), mk(4'b1011, 3'd5, 1'b1, 1'b0));
`ifdef HAMMING_DED_EN
        send(CW_1011 ^ CODE_W'(3), mk(extract(CW_1011 ^ CODE_W'(3)), 3'd3, 1'b0, 1'b1));
`endif
        drain();
        check("corr_cnt_after_single", corr_cnt, 1);

        // Backpressure: fill both stages with the consumer stalled.
        or_force = 1'b0;
        gen(1, c, e); send(c, e);
        gen(0, c, e); send(c, e);
        @(negedge clk);
        check("in_ready_full", in_ready, 0);
        tick();
        tick();
        or_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            gen($urandom_range(0, MAX_ERR), c, e);
            send(c, e);
        end
        drain();

        // Saturation then clear coinciding with a counted handshake.
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            gen(1, c, e);
            send(c, e);
        end
        drain();
        check("corr_cnt_sat", corr_cnt, 3);
        or_force = 1'b0;
        gen(1, c, e);
        send(c, e);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("sixth_word_valid", out_valid, 1);
        tick();
        clr_cnt  = 1'b1;
        or_force = 1'b1;
        tick();
        clr_cnt = 1'b0;
        @(negedge clk);
        check("corr_cnt_clr", corr_cnt, 0);
        tick();

        // Random traffic with random backpressure.
        bp_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            gen($urandom_range(0, MAX_ERR), c, e);
            send(c, e);
        end
        bp_rand = 1'b0;
        drain();

        // Reset with two words in flight.
        gen(1, c, e); send(c, e);
        gen(1, c, e); send(c, e);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("reset_out_valid_now", out_valid, 0);
        check("reset_counters_now", {corr_cnt, unc_cnt}, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_midreset", in_ready, 1);
        check("out_valid_after_midreset", out_valid, 0);
        repeat (3) @(negedge clk);
        check("counters_after_midreset", {corr_cnt, unc_cnt}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
